// File: rtl/pipe_pkg.sv
// Shared definitions for the handshake pipeline stage: state encodings,
// the RISC-V NOP bubble and the ID/EX payload layout.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam logic [31:0] RV_NOP = 32'h00000013;

    // ID/EX payload, packed LSB-first: reg_wen, rd_addr, op2, op1, inst_addr, inst
    localparam int IDEX_REG_WEN_W   = 1;
    localparam int IDEX_RD_ADDR_W   = 5;
    localparam int IDEX_OP_W        = 32;
    localparam int IDEX_INST_ADDR_W = 32;
    localparam int IDEX_INST_W      = 32;

    localparam int IDEX_REG_WEN_LSB   = 0;
    localparam int IDEX_RD_ADDR_LSB   = IDEX_REG_WEN_LSB + IDEX_REG_WEN_W;
    localparam int IDEX_OP2_LSB       = IDEX_RD_ADDR_LSB + IDEX_RD_ADDR_W;
    localparam int IDEX_OP1_LSB       = IDEX_OP2_LSB + IDEX_OP_W;
    localparam int IDEX_INST_ADDR_LSB = IDEX_OP1_LSB + IDEX_OP_W;
    localparam int IDEX_INST_LSB      = IDEX_INST_ADDR_LSB + IDEX_INST_ADDR_W;
    localparam int IDEX_DW            = IDEX_INST_LSB + IDEX_INST_W;

    // Bubble for the ID/EX instance: everything zero except a NOP instruction.
    function automatic logic [IDEX_DW-1:0] idex_bubble();
        logic [IDEX_DW-1:0] b;
        b = '0;
        b[IDEX_INST_LSB +: IDEX_INST_W] = RV_NOP;
        return b;
    endfunction

endpackage

// File: rtl/pipe_stage_hs_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Generic pipeline stage: valid/ready handshake, 2-entry skid (main + skid),
// flush, BUBBLE on empty output and a saturating stall counter.
//
//   state    | meaning
//   ST_EMPTY | nothing held, output shows BUBBLE
//   ST_BUSY  | one payload in main, presented downstream
//   ST_FULL  | main presented, skid holds the next payload, in_ready low
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int              DW     = 32,
    parameter logic [DW-1:0]   BUBBLE = {DW{1'b0}},
    parameter int              CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [DW-1:0]    in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [DW-1:0]    out_data_o,
    output logic [1:0]       occ_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    input  logic             stall_clr_i
);

    state_e          state_q, state_d;
    logic [DW-1:0]   main_q, main_d;
    logic [DW-1:0]   skid_q, skid_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;
    logic            acc, pop;

    assign acc = in_valid_i & in_ready_q;
    assign pop = out_valid_q & out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush_i) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        main_d  = in_data_i;
                        state_d = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (acc && !pop) begin
                        skid_d  = in_data_i;
                        state_d = ST_FULL;
                    end else if (acc && pop) begin
                        main_d  = in_data_i;
                    end else if (pop) begin
                        main_d  = BUBBLE;
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a pop can move the state
                    if (pop) begin
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                        state_d = ST_BUSY;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end

        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= BUBBLE;
            skid_q      <= BUBBLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (out_valid_q & ~out_ready_i & ~flush_i),
        .clr_i (stall_clr_i),
        .cnt_o (stall_cnt_o)
    );

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = main_q;
    assign occ_o       = state_q;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed and random checks of pipe_stage_hs against a queue-based model;
// a second instance with a 4-bit stall counter exercises saturation.
module tb_pipe_stage_hs;
    import pipe_pkg::*;

    localparam logic [31:0] BUB = RV_NOP;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        stall_clr = 1'b0;

    logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [31:0] a_out_data, b_out_data;
    logic [1:0]  a_occ, b_occ;
    logic [15:0] a_cnt;
    logic [3:0]  b_cnt;

    int checks = 0;
    int errors = 0;

    // reference model: contents in acceptance order plus predicted outputs
    logic [31:0] q[$];
    logic [31:0] popped[$];
    logic        m_rdy = 1'b0;
    logic        m_vld = 1'b0;
    int          m_cnt_a = 0;
    int          m_cnt_b = 0;

    always #5 clk = ~clk;

    pipe_stage_hs #(.DW(32), .BUBBLE(BUB), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(a_in_ready), .in_data_i(in_data),
        .out_valid_o(a_out_valid), .out_ready_i(out_ready), .out_data_o(a_out_data),
        .occ_o(a_occ), .stall_cnt_o(a_cnt), .stall_clr_i(stall_clr)
    );

    pipe_stage_hs #(.DW(32), .BUBBLE(BUB), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(b_in_ready), .in_data_i(in_data),
        .out_valid_o(b_out_valid), .out_ready_i(out_ready), .out_data_o(b_out_data),
        .occ_o(b_occ), .stall_cnt_o(b_cnt), .stall_clr_i(stall_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rdy   = 1'b0;
        m_vld   = 1'b0;
        m_cnt_a = 0;
        m_cnt_b = 0;
    endtask

    task automatic model_edge();
        logic acc, pop, stall;
        if (!rst) begin
            model_reset();
            return;
        end
        acc   = in_valid && m_rdy;
        pop   = m_vld && out_ready;
        stall = m_vld && !out_ready && !flush;
        if (pop) begin
            popped.push_back(q[0]);
            void'(q.pop_front());
        end
        if (flush) q.delete();
        else if (acc) q.push_back(in_data);
        m_rdy = (q.size() < 2);
        m_vld = (q.size() > 0);
        if (stall_clr) begin
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else if (stall) begin
            if (m_cnt_a < 65535) m_cnt_a++;
            if (m_cnt_b < 15)    m_cnt_b++;
        end
    endtask

    task automatic check_all();
        logic [31:0] exp_data;
        exp_data = (q.size() > 0) ? q[0] : BUB;
        chk("a_occ",   32'(a_occ),       32'(q.size()));
        chk("a_rdy",   32'(a_in_ready),  32'(m_rdy));
        chk("a_vld",   32'(a_out_valid), 32'(m_vld));
        chk("a_data",  a_out_data,       exp_data);
        chk("a_cnt",   32'(a_cnt),       32'(m_cnt_a));
        chk("b_occ",   32'(b_occ),       32'(q.size()));
        chk("b_rdy",   32'(b_in_ready),  32'(m_rdy));
        chk("b_vld",   32'(b_out_valid), 32'(m_vld));
        chk("b_data",  b_out_data,       exp_data);
        chk("b_cnt",   32'(b_cnt),       32'(m_cnt_b));
    endtask

    task automatic cyc(input logic v, input logic [31:0] d, input logic r,
                       input logic f, input logic c);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        stall_clr = c;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int n;

        // reset held with valid input
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
        chk("rst_vld",  32'(a_out_valid), 32'd0);
        chk("rst_data", a_out_data,       BUB);
        chk("rst_rdy",  32'(a_in_ready),  32'd0);
        chk("rst_occ",  32'(a_occ),       32'd0);
        rst = 1'b1;
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("rdy_after_rst", 32'(a_in_ready), 32'd1);

        // streaming 1..10 at full rate
        popped.delete();
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
            chk("stream_occ", 32'(a_occ), 32'd1);
        end
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("stream_count", 32'(popped.size()), 32'd10);
        for (int i = 0; i < 10 && i < popped.size(); i++)
            chk("stream_order", popped[i], 32'(i + 1));

        // backpressure: A, B fill the stage, C waits upstream
        popped.delete();
        cyc(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        chk("bp_full_occ", 32'(a_occ),      32'd2);
        chk("bp_full_rdy", 32'(a_in_ready), 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
        chk("bp_stall_cnt", 32'(a_cnt), 32'd4);
        cyc(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("bp_count", 32'(popped.size()), 32'd3);
        if (popped.size() == 3) begin
            chk("bp_ord0", popped[0], 32'hA);
            chk("bp_ord1", popped[1], 32'hB);
            chk("bp_ord2", popped[2], 32'hC);
        end

        // flush while FULL with 0xD presented
        popped.delete();
        cyc(1'b1, 32'h1A, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h1B, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hD,  1'b0, 1'b1, 1'b0);
        chk("fl_occ",  32'(a_occ),       32'd0);
        chk("fl_vld",  32'(a_out_valid), 32'd0);
        chk("fl_data", a_out_data,       BUB);
        chk("fl_rdy",  32'(a_in_ready),  32'd1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        n = 0;
        foreach (popped[i]) if (popped[i] == 32'hD) n++;
        chk("fl_no_D", 32'(n), 32'd0);

        // saturation of the 4-bit counter, then clear during the stall
        cyc(1'b1, 32'h77, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("sat_b", 32'(b_cnt), 32'd15);
        chk("sat_a", 32'(a_cnt), 32'd20);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("clr_b", 32'(b_cnt), 32'd0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("reinc_b", 32'(b_cnt), 32'd1);

        // asynchronous reset in mid-cycle with payloads buffered
        cyc(1'b1, 32'h88, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("arst_occ",  32'(a_occ),       32'd0);
        chk("arst_vld",  32'(a_out_valid), 32'd0);
        chk("arst_data", a_out_data,       BUB);
        chk("arst_rdy",  32'(a_in_ready),  32'd0);
        chk("arst_cnt",  32'(a_cnt),       32'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // random traffic
        popped.delete();
        for (int i = 0; i < 10000; i++) begin
            cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
